// File: rtl/decimal2binary_pkg.sv
// Shared definitions for the BCD <-> binary converter pair: FSM encodings and
// BCD digit constants.
package decimal2binary_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ACCUM = 2'b01,
        S_DONE  = 2'b10
    } state_t;

    localparam int          BCD_DIGIT_W   = 4;
    localparam logic [3:0]  BCD_MAX_DIGIT = 4'd9;

    function automatic logic bcd_digit_bad(input logic [BCD_DIGIT_W-1:0] d);
        return d > BCD_MAX_DIGIT;
    endfunction

endpackage

// File: rtl/bcd_mac_digit.sv
// One Horner step of BCD-to-binary conversion: acc*10 + digit, plus a flag
// for a nibble that is not a legal decimal digit.
module bcd_mac_digit
    import decimal2binary_pkg::*;
#(
    parameter int ACC_W = 20
) (
    input  logic [ACC_W-1:0]       acc,
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [ACC_W-1:0]       acc_next,
    output logic                   digit_bad
);

    // acc*10 as shift-add; the caller sizes ACC_W so this never wraps
    always_comb begin
        acc_next  = (acc << 3) + (acc << 1) + ACC_W'(digit);
        digit_bad = bcd_digit_bad(digit);
    end

endmodule

// File: rtl/decimal2binary.sv
// Iterative packed-BCD to unsigned binary converter, one digit per clock,
// most significant digit first, with level start / held done handshake.
module decimal2binary
    import decimal2binary_pkg::*;
#(
    parameter int NDIGITS = 5,
    parameter int OUT_W   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [BCD_DIGIT_W*NDIGITS-1:0] din,
    output logic [OUT_W-1:0]              out,
    output logic                          done1,
    output logic                          err,
    output logic                          ovf
);

    localparam int ACC_W = BCD_DIGIT_W * NDIGITS;
    localparam int CNT_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam int EXT_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
    localparam logic [EXT_W-1:0] OUT_LIM  = (EXT_W'(1) << OUT_W) - EXT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NDIGITS - 1);

    state_t             state;
    logic [ACC_W-1:0]   sr;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic               bad;

    logic [ACC_W-1:0]   acc_next;
    logic               digit_bad;
    logic               bad_final;
    logic [OUT_W-1:0]   res_out;
    logic               res_err;
    logic               res_ovf;

    // Result selection: an illegal digit wins over overflow, overflow saturates.
    function automatic logic [OUT_W+1:0] resolve(input logic [ACC_W-1:0] f,
                                                 input logic             is_bad);
        logic [EXT_W-1:0] fe;
        fe = EXT_W'(f);
        if (is_bad)
            return {{OUT_W{1'b0}}, 1'b1, 1'b0};
        else if (fe > OUT_LIM)
            return {{OUT_W{1'b1}}, 1'b0, 1'b1};
        else
            return {OUT_W'(f), 1'b0, 1'b0};
    endfunction

    bcd_mac_digit #(
        .ACC_W (ACC_W)
    ) u_mac (
        .acc       (acc),
        .digit     (sr[ACC_W-1 -: BCD_DIGIT_W]),
        .acc_next  (acc_next),
        .digit_bad (digit_bad)
    );

    always_comb begin
        bad_final = bad | digit_bad;
        {res_out, res_err, res_ovf} = resolve(acc_next, bad_final);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            sr    <= '0;
            acc   <= '0;
            cnt   <= '0;
            bad   <= 1'b0;
            out   <= '0;
            done1 <= 1'b0;
            err   <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done1 <= 1'b0;
                    if (start) begin
                        sr    <= din;
                        acc   <= '0;
                        cnt   <= '0;
                        bad   <= 1'b0;
                        state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    acc <= acc_next;
                    bad <= bad_final;
                    sr  <= sr << BCD_DIGIT_W;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        out   <= res_out;
                        err   <= res_err;
                        ovf   <= res_ovf;
                        cnt   <= '0;
                        done1 <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // done1 tracks S_DONE exactly, so it drops as we leave
                    if (!start) begin
                        done1 <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        done1 <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_decimal2binary.sv
// Bench for decimal2binary: transaction-level reference model compared every
// cycle, plus directed conversions with hand-computed results.
module tb_decimal2binary;

    localparam int NDIGITS = 5;
    localparam int OUT_W   = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [19:0] din = '0;
    logic [15:0] out;
    logic        done1, err, ovf;

    int n_checks = 0;
    int n_fail   = 0;

    decimal2binary #(.NDIGITS(NDIGITS), .OUT_W(OUT_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .din   (din),
        .out   (out),
        .done1 (done1),
        .err   (err),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     nm, act, act, exp_v, exp_v, $time);
        end
    endtask

    // Decimal value of the BCD word as plain arithmetic, then the result rules.
    function automatic void model_calc(input logic [19:0] d, output logic [15:0] o,
                                       output logic e, output logic v);
        int   val;
        int   pw;
        logic [3:0] nib;
        bit   b;
        val = 0; pw = 1; b = 0;
        for (int i = 0; i < NDIGITS; i++) begin
            nib = d[4*i +: 4];
            val += int'(nib) * pw;
            pw  *= 10;
            if (nib > 4'd9) b = 1;
        end
        if (b) begin
            o = 16'h0; e = 1'b1; v = 1'b0;
        end else if (val > 65535) begin
            o = 16'hFFFF; e = 1'b0; v = 1'b1;
        end else begin
            o = val[15:0]; e = 1'b0; v = 1'b0;
        end
    endfunction

    // Reference model: idle / busy for NDIGITS edges / done until start drops
    int          m_phase = 0;
    int          m_left  = 0;
    logic [19:0] m_din   = '0;
    logic [15:0] exp_out = '0;
    logic        exp_err = 1'b0, exp_ovf = 1'b0, exp_done = 1'b0;
    bit          model_valid = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0; m_left = 0;
            exp_out = '0; exp_err = 0; exp_ovf = 0; exp_done = 0;
            model_valid = 1;
        end else begin
            case (m_phase)
                0: begin
                    exp_done = 0;
                    if (start) begin
                        m_din = din; m_left = NDIGITS; m_phase = 1;
                    end
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        model_calc(m_din, exp_out, exp_err, exp_ovf);
                        exp_done = 1; m_phase = 2;
                    end
                end
                default: begin
                    if (!start) begin
                        exp_done = 0; m_phase = 0;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("cyc_out",   int'(out),   int'(exp_out));
            check("cyc_err",   int'(err),   int'(exp_err));
            check("cyc_ovf",   int'(ovf),   int'(exp_ovf));
            check("cyc_done1", int'(done1), int'(exp_done));
        end
    end

    task automatic run_conv(input string nm, input logic [19:0] d, input logic [15:0] eo,
                            input logic ee, input logic ev);
        int lat;
        @(posedge clk); #2;
        din = d; start = 1'b1;
        @(posedge clk); #2;
        lat = 0;
        while (lat < 12) begin
            @(posedge clk); lat++; #1;
            if (done1) break;
        end
        check({nm, "_latency"}, lat, NDIGITS);
        check({nm, "_out"}, int'(out), int'(eo));
        check({nm, "_err"}, int'(err), int'(ee));
        check({nm, "_ovf"}, int'(ovf), int'(ev));
        #1 start = 1'b0;
        @(posedge clk); #1;
        check({nm, "_done_drop"}, int'(done1), 0);
    endtask

    initial begin
        int rises, highs;
        logic prev;

        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("reset_out",   int'(out),   0);
        check("reset_done1", int'(done1), 0);
        check("reset_err",   int'(err),   0);
        check("reset_ovf",   int'(ovf),   0);

        run_conv("d12345", 20'h12345, 16'h3039, 1'b0, 1'b0);
        run_conv("d65535", 20'h65535, 16'hFFFF, 1'b0, 1'b0);
        run_conv("d65536", 20'h65536, 16'hFFFF, 1'b0, 1'b1);
        run_conv("d99999", 20'h99999, 16'hFFFF, 1'b0, 1'b1);
        run_conv("d1A000", 20'h1A000, 16'h0000, 1'b1, 1'b0);
        run_conv("dF9999", 20'hF9999, 16'h0000, 1'b1, 1'b0);
        run_conv("d00000", 20'h00000, 16'h0000, 1'b0, 1'b0);
        run_conv("d00009", 20'h00009, 16'h0009, 1'b0, 1'b0);

        // Reset on the third accumulate edge discards the partial result
        @(posedge clk); #2;
        din = 20'h54321; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_done1", int'(done1), 0);
        check("midrst_out",   int'(out),   0);
        #1 rst = 1'b0;
        repeat (8) @(posedge clk);
        #1 check("midrst_no_done", int'(done1), 0);
        run_conv("d54321", 20'h54321, 16'hD431, 1'b0, 1'b0);

        // Start held high: a single conversion, done1 held
        @(posedge clk); #2;
        din = 20'h00100; start = 1'b1;
        rises = 0; prev = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done1 && !prev) rises++;
            prev = done1;
        end
        check("hold_rises", rises, 1);
        check("hold_done1", int'(done1), 1);
        check("hold_out",   int'(out), 16'h0064);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("hold_release", int'(done1), 0);

        // One-cycle start pulse: done1 high for exactly one cycle
        @(posedge clk); #2;
        din = 20'h00777; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        highs = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done1) highs++;
        end
        check("pulse_highs", highs, 1);
        check("pulse_out",   int'(out), 16'h0309);

        // din changes after acceptance are ignored
        @(posedge clk); #2;
        din = 20'h00042; start = 1'b1;
        @(posedge clk); #2;
        din = 20'h99999; start = 1'b0;
        @(posedge clk); #2;
        din = 20'h12345;
        repeat (8) @(posedge clk);
        #1;
        check("dinchg_out", int'(out), 16'h002A);
        check("dinchg_err", int'(err), 0);
        check("dinchg_ovf", int'(ovf), 0);

        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
